// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, frame constants and baud divisor helper for the UART transmitter
package uart_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT = 1'b1;
   localparam int DATA_BITS = 8;
   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: show-ahead byte FIFO with registered count, full and empty
module uart_byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     I_clk,
   input  logic                     I_rst,
   input  logic                     I_push,
   input  logic                     I_pop,
   input  logic [7:0]               I_data,
   output logic [7:0]               O_data,
   output logic [$clog2(DEPTH):0]   O_count,
   output logic                     O_full,
   output logic                     O_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   always_comb begin
      do_push = I_push && !O_full;
      do_pop = I_pop && !O_empty;
      wr_d = do_push ? wr_q + 1'b1 : wr_q;
      rd_d = do_pop ? rd_q + 1'b1 : rd_q;
      cnt_d = (do_push && !do_pop) ? cnt_q + 1'b1 : (!do_push && do_pop) ? cnt_q - 1'b1 : cnt_q;
   end
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge I_clk) begin
      if (do_push) mem_q[wr_q] <= I_data;
   end
   assign O_data = mem_q[rd_q];
   assign O_count = cnt_q;
   assign O_full = cnt_q == (AW+1)'(DEPTH);
   assign O_empty = cnt_q == '0;
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter with its own baud counter
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD = 9600,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       I_clk,
   input  logic       I_rst,
   input  logic       I_wr_en,
   input  logic [7:0] I_wr_data,
   output logic       O_full,
   output logic       O_empty,
   output logic       O_busy,
   output logic       O_tx_done,
   output logic       O_ovf,
   output logic       O_rs232_txd
);
   localparam int DIV = baud_div(CLK_FREQ, BAUD);
   localparam int BW = $clog2(DIV);
   state_t state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] sh_q, sh_d, head;
   logic txd_q, txd_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   logic tick, pop, fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .I_clk(I_clk), .I_rst(I_rst), .I_push(I_wr_en), .I_pop(pop), .I_data(I_wr_data),
      .O_data(head), .O_count(fifo_count), .O_full(fifo_full), .O_empty(fifo_empty)
   );
   always_comb begin
      tick = baud_q == BW'(DIV - 1);
      state_d = state_q;
      baud_d = tick ? '0 : baud_q + 1'b1;
      bit_d = bit_q;
      sh_d = sh_q;
      pop = 1'b0;
      done_d = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               state_d = START;
               pop = 1'b1;
               sh_d = head;
               bit_d = '0;
            end
         end
         START: if (tick) state_d = DATA;
         DATA: if (tick) begin
            sh_d = sh_q >> 1;
            bit_d = bit_q + 1'b1;
            if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
         end
         STOP: begin
            // registered pulse must coincide with the last clock of the stop bit
            done_d = baud_q == BW'(DIV - 2);
            if (tick) begin
               state_d = fifo_empty ? IDLE : START;
               pop = !fifo_empty;
               sh_d = fifo_empty ? sh_q : head;
               bit_d = '0;
            end
         end
      endcase
      txd_d = state_d == START ? START_BIT : state_d == DATA ? sh_d[0] : STOP_BIT;
      busy_d = state_d != IDLE;
      ovf_d = ovf_q || (I_wr_en && fifo_count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
   end
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q <= IDLE;
         baud_q <= '0;
         bit_q <= '0;
         sh_q <= '0;
         txd_q <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q <= baud_d;
         bit_q <= bit_d;
         sh_q <= sh_d;
         txd_q <= txd_d;
         busy_q <= busy_d;
         done_q <= done_d;
         ovf_q <= ovf_d;
      end
   end
   assign O_full = fifo_full;
   assign O_empty = fifo_empty;
   assign O_busy = busy_q;
   assign O_tx_done = done_q;
   assign O_ovf = ovf_q;
   assign O_rs232_txd = txd_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed scoreboard bench for the buffered UART transmitter
module tb_uart_tx_buffered;
   logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic full, empty, busy, done, ovf, txd;
   int cyc = 0, errors = 0, checks = 0;
   int mc = 0, mt = 0;
   bit mbusy = 0, movf = 0, m_push, m_pop;
   logic [7:0] exp_q[$];
   logic [8:0] rx_q[$];
   int st_q[$], td_q[$];
   int rx_idx = 0;
   bit rx_on = 0, rx_ok;
   int rx_t;
   logic [7:0] rx_b;

   uart_tx_buffered #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(16)) dut (
      .I_clk(clk), .I_rst(rst), .I_wr_en(wr_en), .I_wr_data(wr_data),
      .O_full(full), .O_empty(empty), .O_busy(busy), .O_tx_done(done),
      .O_ovf(ovf), .O_rs232_txd(txd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // reference occupancy model: one frame occupies 100 clocks from the pop
   always @(posedge clk) begin
      if (rst) begin
         mc = 0; mt = 0; mbusy = 0; movf = 0;
      end else begin
         if (wr_en && mc == 16) movf = 1;
         m_push = wr_en && mc < 16;
         m_pop = mc > 0 && (!mbusy || mt == 99);
         if (mbusy && mt != 99) mt++;
         else begin
            mbusy = mc > 0;
            mt = 0;
         end
         mc = mc + int'(m_push) - int'(m_pop);
      end
   end

   // line receiver sampling mid-bit, 10 clocks per bit
   always @(negedge clk) begin
      if (rst) rx_on = 0;
      else if (!rx_on) begin
         if (txd === 1'b0) begin
            rx_on = 1; rx_t = 0; rx_ok = 1;
            st_q.push_back(cyc);
         end
      end else begin
         rx_t++;
         if (rx_t == 5) rx_ok &= (txd === 1'b0);
         else if (rx_t >= 15 && rx_t <= 85 && rx_t % 10 == 5) rx_b[(rx_t - 15) / 10] = txd;
         else if (rx_t == 95) begin
            rx_ok &= (txd === 1'b1);
            rx_q.push_back({rx_ok, rx_b});
            rx_on = 0;
         end
      end
      if (done === 1'b1) td_q.push_back(cyc);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr_byte(input logic [7:0] d);
      wr_en = 1'b1;
      wr_data = d;
      if (mc < 16) exp_q.push_back(d);
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   task automatic wait_cycle(input int t);
      @(negedge clk);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_rx(input int n);
      int b = 0;
      while (rx_q.size() < rx_idx + n && b < 250 * n) begin
         @(negedge clk);
         b++;
      end
      check("rx_timeout", 32'(rx_q.size() >= rx_idx + n), 1);
   endtask

   task automatic check_frames(input int n);
      for (int i = 0; i < n; i++) begin
         if (rx_idx < rx_q.size()) begin
            check("frame", 32'(rx_q[rx_idx]), exp_q.size() > 0 ? 32'({1'b1, exp_q.pop_front()}) : 32'h1ff);
            rx_idx++;
         end
      end
   endtask

   initial begin
      int n, td0, rxn, b;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_txd", 32'(txd), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_ovf", 32'(ovf), 0);
      check("rst_full", 32'(full), 0);
      check("rst_empty", 32'(empty), 1);

      @(posedge clk); #1;
      n = cyc;
      wr_byte(8'hA5);
      wait_cycle(n + 1);
      check("a5_txd_n1", 32'(txd), 1);
      wait_cycle(n + 2);
      check("a5_txd_n2", 32'(txd), 0);
      check("a5_busy", 32'(busy), 1);
      wait_cycle(n + 101);
      check("a5_done", 32'(done), 1);
      wait_cycle(n + 102);
      check("a5_done_off", 32'(done), 0);
      check("a5_busy_off", 32'(busy), 0);
      check("a5_start_cyc", 32'(st_q[$]), 32'(n + 2));
      check("a5_done_cyc", 32'(td_q[$]), 32'(n + 101));
      wait_rx(1);
      check_frames(1);

      td0 = td_q.size();
      @(posedge clk); #1;
      wr_byte(8'h00);
      wr_byte(8'hFF);
      wr_byte(8'h3C);
      wait_rx(3);
      repeat (10) @(negedge clk);
      check_frames(3);
      check("b2b_start1", 32'(st_q[$] - st_q[$-1]), 100);
      check("b2b_start0", 32'(st_q[$-1] - st_q[$-2]), 100);
      check("b2b_ndone", 32'(td_q.size() - td0), 3);
      check("b2b_done1", 32'(td_q[$] - td_q[$-1]), 100);
      check("b2b_done0", 32'(td_q[$-1] - td_q[$-2]), 100);

      @(posedge clk); #1;
      for (int i = 0; i < 17; i++) wr_byte(8'h40 + 8'(i));
      @(negedge clk);
      check("burst_full", 32'(full), 1);
      check("burst_ovf0", 32'(ovf), 32'(movf));
      @(posedge clk); #1;
      wr_byte(8'hEE);
      @(negedge clk);
      check("drop_ovf", 32'(ovf), 32'(movf));
      check("drop_ovf1", 32'(ovf), 1);
      b = 0;
      while (done !== 1'b1 && b < 200) begin
         @(negedge clk);
         b++;
      end
      check("stop_end_seen", 32'(done), 1);
      check("stop_end_full", 32'(full), 1);
      wr_en = 1'b1;
      wr_data = 8'h77;
      if (mc < 16) exp_q.push_back(8'h77);
      @(posedge clk);
      #1 wr_en = 1'b0;
      @(negedge clk);
      check("pop_full_off", 32'(full), 0);
      check("pop_ovf", 32'(ovf), 1);
      wait_rx(17);
      check_frames(17);
      check("ovf_sticky", 32'(ovf), 1);

      repeat (20) @(negedge clk);
      @(posedge clk); #1;
      n = cyc;
      wr_byte(8'h55);
      wr_byte(8'h11);
      wr_byte(8'h22);
      wr_byte(8'h33);
      wait_cycle(n + 42);
      check("abort_busy", 32'(busy), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      td0 = td_q.size();
      rxn = rx_q.size();
      @(negedge clk);
      check("abort_txd", 32'(txd), 1);
      check("abort_empty", 32'(empty), 1);
      check("abort_busy0", 32'(busy), 0);
      check("abort_ovf", 32'(ovf), 0);
      repeat (300) @(negedge clk);
      check("abort_nodone", 32'(td_q.size()), 32'(td0));
      check("abort_noframe", 32'(rx_q.size()), 32'(rxn));
      check("abort_idle_txd", 32'(txd), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
